// File: rtl/arm_hazard_scoreboard.sv
// Hazard/forwarding controller between decode and execute: tracks in-flight writers,
// selects forwarding sources, and stalls on load-use, MAC occupancy, CPSR and halt drain.
// Optional build macro ARM_CPSR_FWD_EN adds cpsr_fwd_sel and removes most CPSR stalls.
module arm_hazard_scoreboard #(
    parameter int NUM_RD_PORTS = 3,
    parameter int NUM_STAGES   = 3,
    parameter int REG_AW       = 4,
    parameter int MAC_LAT      = 2,
    parameter int FW           = $clog2(NUM_STAGES + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             dcd_valid,
    input  logic [NUM_RD_PORTS*REG_AW-1:0]   dcd_read_reg_num,
    input  logic [NUM_RD_PORTS-1:0]          dcd_read_mask,
    input  logic                             dcd_rd_we,
    input  logic [REG_AW-1:0]                dcd_rd_num,
    input  logic                             dcd_is_load,
    input  logic                             dcd_is_mac,
    input  logic                             dcd_cpsr_we,
    input  logic                             dcd_is_cond,
    input  logic                             dcd_halt,
    input  logic                             flush,
    output logic                             stall,
    output logic                             issue,
    output logic [NUM_RD_PORTS*FW-1:0]       fwd_sel,
`ifdef ARM_CPSR_FWD_EN
    output logic [FW-1:0]                    cpsr_fwd_sel,
`endif
    output logic                             halted,
    output logic [$clog2(NUM_STAGES+1)-1:0]  busy_cnt
);

    localparam int                MW     = $clog2(MAC_LAT + 1);
    localparam logic [REG_AW-1:0] PC_REG = REG_AW'(15);

    logic              sb_vld     [NUM_STAGES];
    logic              sb_rd_we   [NUM_STAGES];
    logic [REG_AW-1:0] sb_rd      [NUM_STAGES];
    logic              sb_is_load [NUM_STAGES];
    logic              sb_cpsr_we [NUM_STAGES];
    logic [MW-1:0]     mac_cnt;
    logic              halt_pending;

    logic [NUM_RD_PORTS*FW-1:0] sel_raw;
    logic [FW-1:0]              busy_raw;
    logic                       load_use;
    logic                       mac_hold;
    logic                       any_cpsr;
    logic                       cpsr_haz;
    logic                       gate;
    logic                       stall_int;
`ifdef ARM_CPSR_FWD_EN
    logic [FW-1:0]              cpsr_sel_raw;
`endif

    assign mac_hold = (mac_cnt > MW'(1));

    // Scanning oldest to youngest lets the youngest matching writer win.
    always_comb begin
        sel_raw  = '0;
        load_use = 1'b0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (dcd_read_mask[p] &&
                    dcd_read_reg_num[p*REG_AW +: REG_AW] != PC_REG &&
                    sb_vld[k] && sb_rd_we[k] &&
                    sb_rd[k] == dcd_read_reg_num[p*REG_AW +: REG_AW]) begin
                    sel_raw[p*FW +: FW] = FW'(k + 1);
                end
            end
            if (sel_raw[p*FW +: FW] == FW'(1) && sb_is_load[0]) begin
                load_use = 1'b1;
            end
        end
    end

    always_comb begin
        busy_raw = '0;
        any_cpsr = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            busy_raw = busy_raw + FW'(sb_vld[k]);
            if (sb_vld[k] && sb_cpsr_we[k]) begin
                any_cpsr = 1'b1;
            end
        end
    end

`ifdef ARM_CPSR_FWD_EN
    always_comb begin
        cpsr_sel_raw = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (sb_vld[k] && sb_cpsr_we[k]) begin
                cpsr_sel_raw = FW'(k + 1);
            end
        end
    end

    // Flags can be forwarded except from a flag-setting load or a MAC still in EX.
    assign cpsr_haz = dcd_is_cond && sb_vld[0] && sb_cpsr_we[0] &&
                      (sb_is_load[0] || mac_cnt != '0);
    assign cpsr_fwd_sel = rst ? '0 : cpsr_sel_raw;
`else
    assign cpsr_haz = dcd_is_cond && any_cpsr;
`endif

    assign gate      = dcd_valid && !halt_pending && !flush && !rst;
    assign stall_int = gate && (load_use || mac_hold || cpsr_haz);
    assign stall     = stall_int;
    assign issue     = gate && !stall_int;
    assign fwd_sel   = rst ? '0 : sel_raw;
    assign busy_cnt  = rst ? '0 : busy_raw;

    // Control state: entry valids, MAC occupancy, halt tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                sb_vld[k] <= 1'b0;
            end
            mac_cnt      <= '0;
            halt_pending <= 1'b0;
            halted       <= 1'b0;
        end else begin
            if (mac_hold) begin
                mac_cnt <= mac_cnt - MW'(1);
                for (int k = NUM_STAGES - 1; k >= 2; k--) begin
                    sb_vld[k] <= sb_vld[k-1];
                end
                sb_vld[1] <= 1'b0;
            end else begin
                for (int k = NUM_STAGES - 1; k >= 1; k--) begin
                    sb_vld[k] <= sb_vld[k-1];
                end
                sb_vld[0] <= issue;
                mac_cnt   <= (issue && dcd_is_mac) ? MW'(MAC_LAT) : '0;
            end
            if (issue && dcd_halt) begin
                halt_pending <= 1'b1;
            end
            if (halt_pending && busy_raw == '0) begin
                halted <= 1'b1;
            end
        end
    end

    // Entry payload; only meaningful where the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (mac_hold) begin
            for (int k = NUM_STAGES - 1; k >= 2; k--) begin
                sb_rd_we[k]   <= sb_rd_we[k-1];
                sb_rd[k]      <= sb_rd[k-1];
                sb_is_load[k] <= sb_is_load[k-1];
                sb_cpsr_we[k] <= sb_cpsr_we[k-1];
            end
        end else begin
            for (int k = NUM_STAGES - 1; k >= 1; k--) begin
                sb_rd_we[k]   <= sb_rd_we[k-1];
                sb_rd[k]      <= sb_rd[k-1];
                sb_is_load[k] <= sb_is_load[k-1];
                sb_cpsr_we[k] <= sb_cpsr_we[k-1];
            end
            sb_rd_we[0]   <= dcd_rd_we && !dcd_halt;
            sb_rd[0]      <= dcd_rd_num;
            sb_is_load[0] <= dcd_is_load;
            sb_cpsr_we[0] <= dcd_cpsr_we;
        end
    end

endmodule

// File: tb/tb_arm_hazard_scoreboard.sv
// Self-checking bench for arm_hazard_scoreboard: instruction-queue reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_arm_hazard_scoreboard;

    localparam int NRP  = 3;
    localparam int NST  = 3;
    localparam int RAW  = 4;
    localparam int MLAT = 3;
    localparam int FW   = $clog2(NST + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               dcd_valid;
    logic [NRP*RAW-1:0] dcd_read_reg_num;
    logic [NRP-1:0]     dcd_read_mask;
    logic               dcd_rd_we;
    logic [RAW-1:0]     dcd_rd_num;
    logic               dcd_is_load, dcd_is_mac, dcd_cpsr_we, dcd_is_cond, dcd_halt, flush;
    logic               stall, issue, halted;
    logic [NRP*FW-1:0]  fwd_sel;
    logic [FW-1:0]      busy_cnt;
`ifdef ARM_CPSR_FWD_EN
    logic [FW-1:0]      cpsr_fwd_sel;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    arm_hazard_scoreboard #(
        .NUM_RD_PORTS(NRP), .NUM_STAGES(NST), .REG_AW(RAW), .MAC_LAT(MLAT)
    ) dut (
        .clk(clk), .rst(rst), .dcd_valid(dcd_valid),
        .dcd_read_reg_num(dcd_read_reg_num), .dcd_read_mask(dcd_read_mask),
        .dcd_rd_we(dcd_rd_we), .dcd_rd_num(dcd_rd_num), .dcd_is_load(dcd_is_load),
        .dcd_is_mac(dcd_is_mac), .dcd_cpsr_we(dcd_cpsr_we), .dcd_is_cond(dcd_is_cond),
        .dcd_halt(dcd_halt), .flush(flush), .stall(stall), .issue(issue),
        .fwd_sel(fwd_sel),
`ifdef ARM_CPSR_FWD_EN
        .cpsr_fwd_sel(cpsr_fwd_sel),
`endif
        .halted(halted), .busy_cnt(busy_cnt)
    );

    // Reference model: a list of in-flight instructions, each knowing its stage.
    typedef struct {
        int stage;
        bit we;
        int rd;
        bit ld;
        bit cw;
    } ins_t;

    ins_t flight[$];
    int   mac_left  = 0;
    bit   halt_pend = 1'b0;
    bit   m_halted  = 1'b0;

    function automatic int youngest_writer(int r);
        int best = 0;
        if (r == 15) return 0;
        foreach (flight[i]) begin
            if (flight[i].we && flight[i].rd == r && (best == 0 || flight[i].stage + 1 < best))
                best = flight[i].stage + 1;
        end
        return best;
    endfunction

    function automatic void model_eval(output bit e_stall, output bit e_issue,
                                       output logic [NRP*FW-1:0] e_sel,
                                       output int e_busy, output int e_csel);
        bit lu = 1'b0, cz = 1'b0, s0 = 1'b0, s0_ld = 1'b0, s0_cw = 1'b0, any_cw = 1'b0, gate;
        e_sel  = '0;
        e_csel = 0;
        foreach (flight[i]) begin
            if (flight[i].stage == 0) begin
                s0 = 1'b1; s0_ld = flight[i].ld; s0_cw = flight[i].cw;
            end
            if (flight[i].cw) begin
                any_cw = 1'b1;
                if (e_csel == 0 || flight[i].stage + 1 < e_csel) e_csel = flight[i].stage + 1;
            end
        end
        for (int p = 0; p < NRP; p++) begin
            int k = dcd_read_mask[p] ? youngest_writer(int'(dcd_read_reg_num[p*RAW +: RAW])) : 0;
            e_sel[p*FW +: FW] = FW'(k);
            if (k == 1 && s0_ld) lu = 1'b1;
        end
`ifdef ARM_CPSR_FWD_EN
        cz = dcd_is_cond && s0 && s0_cw && (s0_ld || mac_left > 0);
`else
        cz = dcd_is_cond && any_cw;
`endif
        gate    = !rst && dcd_valid && !halt_pend && !flush;
        e_stall = gate && (lu || mac_left > 1 || cz);
        e_issue = gate && !e_stall;
        e_busy  = rst ? 0 : flight.size();
        if (rst) begin
            e_sel  = '0;
            e_csel = 0;
        end
    endfunction

    always @(posedge clk) begin
        bit es, ei, hold;
        logic [NRP*FW-1:0] esel;
        int eb, ec;
        ins_t x;
        ins_t nxt[$];
        model_eval(es, ei, esel, eb, ec);
        if (rst) begin
            flight.delete();
            mac_left  = 0;
            halt_pend = 1'b0;
            m_halted  = 1'b0;
        end else begin
            if (halt_pend && flight.size() == 0) m_halted = 1'b1;
            if (ei && dcd_halt) halt_pend = 1'b1;
            hold = (mac_left > 1);
            nxt.delete();
            foreach (flight[i]) begin
                x = flight[i];
                if (!(hold && x.stage == 0)) x.stage = x.stage + 1;
                if (x.stage < NST) nxt.push_back(x);
            end
            if (hold) begin
                mac_left = mac_left - 1;
            end else begin
                if (ei) begin
                    x.stage = 0;
                    x.we    = dcd_rd_we && !dcd_halt;
                    x.rd    = int'(dcd_rd_num);
                    x.ld    = dcd_is_load;
                    x.cw    = dcd_cpsr_we;
                    nxt.push_back(x);
                end
                mac_left = (ei && dcd_is_mac) ? MLAT : 0;
            end
            flight = nxt;
        end
    end

    task automatic check(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit es, ei;
        logic [NRP*FW-1:0] esel;
        int eb, ec;
        model_eval(es, ei, esel, eb, ec);
        check("model_stall", int'(stall), int'(es));
        check("model_issue", int'(issue), int'(ei));
        for (int p = 0; p < NRP; p++)
            check("model_fwd_sel", int'(fwd_sel[p*FW +: FW]), int'(esel[p*FW +: FW]));
        check("model_busy_cnt", int'(busy_cnt), eb);
        check("model_halted", int'(halted), int'(m_halted));
`ifdef ARM_CPSR_FWD_EN
        check("model_cpsr_fwd_sel", int'(cpsr_fwd_sel), ec);
`endif
    end

    function automatic int fsel(int p);
        return int'(fwd_sel[p*FW +: FW]);
    endfunction

    task automatic drive(bit v, logic [3:0] r0, logic [3:0] r1, logic [3:0] r2, logic [2:0] m,
                         bit we, logic [3:0] rd, bit ld, bit mac, bit cw, bit cond, bit hlt, bit fl);
        dcd_valid        = v;
        dcd_read_reg_num = {r2, r1, r0};
        dcd_read_mask    = m;
        dcd_rd_we        = we;
        dcd_rd_num       = rd;
        dcd_is_load      = ld;
        dcd_is_mac       = mac;
        dcd_cpsr_we      = cw;
        dcd_is_cond      = cond;
        dcd_halt         = hlt;
        flush            = fl;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(int n);
        nop();
        repeat (n) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(1, 1, 0, 0, 3'b001, 1, 2, 1, 0, 0, 0, 0, 0);
        tick(); #1;
        check("reset_stall", int'(stall), 0);
        check("reset_issue", int'(issue), 0);
        check("reset_fwd_sel", int'(fwd_sel), 0);
        check("reset_busy_cnt", int'(busy_cnt), 0);
        rst = 1'b0;
        drain(2);

        // ADD r1 then dependent reads as it moves EX -> MEM -> WB -> retired
        drive(1, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0); #1;
        check("t1_add_issue", int'(issue), 1);
        tick();
        drive(1, 1, 0, 0, 3'b001, 1, 4, 0, 0, 0, 0, 0, 0); #1;
        check("t1_sub_stall", int'(stall), 0);
        check("t1_fwd_ex", fsel(0), 1);
        tick();
        drive(1, 1, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        check("t1_fwd_mem", fsel(0), 2);
        tick();
        drive(0, 1, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        check("t1_fwd_wb", fsel(0), 3);
        tick();
        #1;
        check("t1_fwd_retired", fsel(0), 0);
        drain(4);

        // LDR r2 then ADD reading r2 on port1
        drive(1, 0, 0, 0, 3'b000, 1, 2, 1, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 2, 0, 3'b010, 1, 5, 0, 0, 0, 0, 0, 0); #1;
        check("t2_loaduse_stall", int'(stall), 1);
        check("t2_loaduse_issue", int'(issue), 0);
        tick(); #1;
        check("t2_after_stall", int'(stall), 0);
        check("t2_after_issue", int'(issue), 1);
        check("t2_fwd_mem", fsel(1), 2);
        drain(4);

        // MUL r3 occupies EX for 3 cycles
        drive(1, 0, 0, 0, 3'b000, 1, 3, 0, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 3'b000, 1, 6, 0, 0, 0, 0, 0, 0); #1;
        check("t3_mac_stall1", int'(stall), 1);
        tick(); #1;
        check("t3_mac_stall2", int'(stall), 1);
        tick(); #1;
        check("t3_mac_free", int'(stall), 0);
        check("t3_mov_issue", int'(issue), 1);
        tick();
        drive(1, 0, 0, 3, 3'b100, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        check("t3_fwd_mul_mem", fsel(2), 2);
        drain(5);

        // ADDS then a conditional MOV
        drive(1, 0, 0, 0, 3'b000, 1, 7, 0, 0, 1, 0, 0, 0); tick();
`ifdef ARM_CPSR_FWD_EN
        drive(1, 0, 0, 0, 3'b000, 1, 8, 0, 0, 0, 1, 0, 0); #1;
        check("t4_cond_nostall", int'(stall), 0);
        check("t4_cond_issue", int'(issue), 1);
        check("t4_cpsr_fwd", int'(cpsr_fwd_sel), 1);
        tick();
`else
        drive(1, 0, 0, 0, 3'b000, 1, 8, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_cpsr_stall", int'(stall), 1);
            tick();
        end
        #1;
        check("t4_cpsr_release", int'(stall), 0);
        check("t4_cond_issue", int'(issue), 1);
        tick();
`endif
        drain(5);

        // Flush during load-use, then flush during an active MAC
        drive(1, 0, 0, 0, 3'b000, 1, 9, 1, 0, 0, 0, 0, 0); tick();
        drive(1, 9, 0, 0, 3'b001, 1, 5, 0, 0, 0, 0, 0, 1); #1;
        check("t5_flush_stall", int'(stall), 0);
        check("t5_flush_issue", int'(issue), 0);
        check("t5_busy_before", int'(busy_cnt), 1);
        tick();
        nop(); #1;
        check("t5_busy_after", int'(busy_cnt), 1);
        drain(4);
        drive(1, 0, 0, 0, 3'b000, 1, 10, 0, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 3'b000, 1, 6, 0, 0, 0, 0, 0, 1); #1;
        check("t5_mac_flush_issue", int'(issue), 0);
        tick();
        drive(1, 0, 0, 0, 3'b000, 1, 6, 0, 0, 0, 0, 0, 0); #1;
        check("t5_mac_kept_stall", int'(stall), 1);
        tick(); #1;
        check("t5_mac_done_issue", int'(issue), 1);
        drain(5);

        // r15 never forwards, masked ports ignored, youngest writer wins
        drive(1, 0, 0, 0, 3'b000, 1, 15, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 3'b000, 1, 11, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 15, 11, 11, 3'b011, 1, 11, 0, 0, 0, 0, 0, 0); #1;
        check("x_r15_nofwd", fsel(0), 0);
        check("x_self_rd_older", fsel(1), 1);
        check("x_masked_port", fsel(2), 0);
        tick();
        drive(0, 11, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        check("x_youngest_wins", fsel(0), 1);
        drain(4);

        // Flag-setting load followed by dependent conditional: one stall
        drive(1, 0, 0, 0, 3'b000, 1, 12, 1, 0, 1, 0, 0, 0); tick();
        drive(1, 12, 0, 0, 3'b001, 1, 13, 0, 0, 0, 1, 0, 0); #1;
        check("x_lu_cpsr_stall", int'(stall), 1);
        check("x_lu_cpsr_issue", int'(issue), 0);
        drain(5);

        // ADD r1, SWI, then decode keeps presenting an instruction
        drive(1, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0); #1;
        check("t6_swi_issue", int'(issue), 1);
        tick();
        drive(1, 0, 0, 0, 3'b000, 1, 2, 0, 0, 0, 0, 0, 0); #1;
        check("t6_blocked_issue", int'(issue), 0);
        check("t6_blocked_stall", int'(stall), 0);
        check("t6_busy2a", int'(busy_cnt), 2);
        tick(); #1;
        check("t6_busy2b", int'(busy_cnt), 2);
        tick(); #1;
        check("t6_busy1", int'(busy_cnt), 1);
        tick(); #1;
        check("t6_busy0", int'(busy_cnt), 0);
        check("t6_not_yet_halted", int'(halted), 0);
        tick(); #1;
        check("t6_halted", int'(halted), 1);
        tick(); #1;
        check("t6_halted_sticky", int'(halted), 1);
        rst = 1'b1; #1;
        check("t6_rst_stall", int'(stall), 0);
        check("t6_rst_busy", int'(busy_cnt), 0);
        tick();
        rst = 1'b0; #1;
        check("t6_rst_halted", int'(halted), 0);
        check("t6_rst_issue", int'(issue), 1);
        tick();
        drain(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
